// File: rtl/biu_arb_pkg.sv
// Arbiter types: FSM state enum, owner encoding
// and the state-to-owner mapping.
package biu_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_IM = 2'd1,
    ARB_GNT_DM = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IM   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;

  function automatic logic [1:0] own_of(
    input arb_state_t s
  );
    logic [1:0] o;
    o = OWN_NONE;
    unique case (s)
      ARB_GNT_IM: o = OWN_IM;
      ARB_GNT_DM: o = OWN_DM;
      default:    o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/biu_constants_pkg.sv
// BIU shared constants: transfer size encoding
// used by the core ports, the arbiter and the external BIU.
package biu_constants_pkg;

  typedef enum logic [1:0] {
    BIU_SIZE_B = 2'd0,
    BIU_SIZE_H = 2'd1,
    BIU_SIZE_W = 2'd2
  } biu_size_t;

endpackage

// File: rtl/biu_arb_watchdog.sv
// Grant watchdog: counts cycles spent in a grant
// state and flags the cycle the limit is reached.
module biu_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // first grant cycle sees 0, so the flag fires
  // in grant cycle number TIMEOUT_CYCLES
  assign o_timeout = i_active &&
    (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // count while granted, clear whenever idle
  always_ff @(posedge clk) begin
    if (rst || !i_active) begin
      r_cnt <= '0;
    end else if (!o_timeout) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/biu_mem_arbiter.sv
// Fetch/data bus arbiter, one transaction in flight.
// Optional watchdog: define ARB_WATCHDOG_EN.
module biu_mem_arbiter
  import biu_constants_pkg::*;
  import biu_arb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int DM_BURST_MAX   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            im_req,
  input  logic [XLEN-1:0] im_adr,
  input  biu_size_t       im_size,
  output logic [XLEN-1:0] im_q,
  output logic            im_ack,
  output logic            im_err,
  input  logic            dm_req,
  input  logic [XLEN-1:0] dm_adr,
  input  logic [XLEN-1:0] dm_d,
  input  logic            dm_we,
  input  biu_size_t       dm_size,
  output logic [XLEN-1:0] dm_q,
  output logic            dm_ack,
  output logic            dm_err,
  output logic            bus_req,
  output logic [XLEN-1:0] bus_adr,
  output logic [XLEN-1:0] bus_d,
  output logic            bus_we,
  output biu_size_t       bus_size,
  input  logic [XLEN-1:0] bus_q,
  input  logic            bus_ack,
  input  logic            bus_err,
  output logic [1:0]      owner
);

  localparam int SW = $clog2(DM_BURST_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(DM_BURST_MAX);

  if (DM_BURST_MAX < 1) begin : g_chk_burst
    $error("DM_BURST_MAX must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_tmo
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic [SW-1:0] r_starve;
  logic          w_tmo;
  logic          w_tmo_hit;
  logic          w_done;

`ifdef ARB_WATCHDOG_EN
  biu_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_active (r_state != ARB_IDLE),
    .o_timeout(w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  // a real bus response in the limit cycle wins
  assign w_tmo_hit = w_tmo && !bus_ack && !bus_err;
  assign w_done    = bus_ack || bus_err || w_tmo;
  assign owner     = own_of(r_state);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state: dm first unless im has starved
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (dm_req && im_req) begin
          w_next = (r_starve == SMAX) ?
            ARB_GNT_IM : ARB_GNT_DM;
        end else if (dm_req) begin
          w_next = ARB_GNT_DM;
        end else if (im_req) begin
          w_next = ARB_GNT_IM;
        end
      end
      ARB_GNT_IM, ARB_GNT_DM: begin
        if (w_done) w_next = ARB_IDLE;
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  // starvation counter: dm grants while im waits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (r_state == ARB_IDLE) begin
      if (w_next == ARB_GNT_IM || !im_req) begin
        r_starve <= '0;
      end else if (w_next == ARB_GNT_DM &&
                   r_starve != SMAX) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  // outputs: bus mux and response routing
  always_comb begin
    bus_req  = 1'b0;
    bus_adr  = '0;
    bus_d    = '0;
    bus_we   = 1'b0;
    bus_size = BIU_SIZE_B;
    im_q     = '0;
    im_ack   = 1'b0;
    im_err   = 1'b0;
    dm_q     = '0;
    dm_ack   = 1'b0;
    dm_err   = 1'b0;
    unique case (r_state)
      ARB_GNT_IM: begin
        bus_req  = 1'b1;
        bus_adr  = im_adr;
        bus_size = im_size;
        im_q     = bus_q;
        im_ack   = bus_ack && !bus_err;
        im_err   = bus_err || w_tmo_hit;
      end
      ARB_GNT_DM: begin
        bus_req  = 1'b1;
        bus_adr  = dm_adr;
        bus_d    = dm_d;
        bus_we   = dm_we;
        bus_size = dm_size;
        dm_q     = bus_q;
        dm_ack   = bus_ack && !bus_err;
        dm_err   = bus_err || w_tmo_hit;
      end
      default: ;
    endcase
  end

endmodule
